// File: rtl/sram_port_arbiter.sv
// Inst/data arbiter onto one fixed-latency single-port SRAM, one access in flight.
// Define ARB_ROUND_ROBIN_EN to alternate grants on ties; default is data-over-inst.
module sram_port_arbiter #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_en,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam logic [2:0] LAT3 = 3'(MEM_LAT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state, state_nx;
  logic [2:0]  cnt;
  logic        gnt_inst, gnt_data;
  logic        lat_wr, lat_data, last_data;
  logic        sel_wr;
  logic [3:0]  sel_wstrb;
  logic [31:0] sel_addr, sel_wdata;

  always_comb begin
    gnt_inst = 1'b0;
    gnt_data = 1'b0;
    state_nx = state;
    unique case (state)
      IDLE: begin
`ifdef ARB_ROUND_ROBIN_EN
        if (inst_req && data_req) begin
          gnt_inst = last_data;
          gnt_data = !last_data;
        end else begin
          gnt_inst = inst_req;
          gnt_data = data_req;
        end
`else
        gnt_data = data_req;
        gnt_inst = inst_req && !data_req;
`endif
        if (inst_req || data_req) state_nx = ISSUE;
      end
      ISSUE: state_nx = WAIT;
      WAIT: if (cnt == 3'd1) state_nx = RESP;
      RESP: state_nx = IDLE;
    endcase
  end

  assign inst_addr_ok = gnt_inst;
  assign data_addr_ok = gnt_data;
  assign busy         = (state != IDLE);

  assign sel_wr    = gnt_data ? data_wr    : inst_wr;
  assign sel_wstrb = gnt_data ? data_wstrb : inst_wstrb;
  assign sel_addr  = gnt_data ? data_addr  : inst_addr;
  assign sel_wdata = gnt_data ? data_wdata : inst_wdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt          <= 3'd0;
      lat_wr       <= 1'b0;
      lat_data     <= 1'b0;
      last_data    <= 1'b1;
      mem_en       <= 1'b0;
      mem_wen      <= 4'b0000;
      mem_addr     <= 32'd0;
      mem_wdata    <= 32'd0;
      inst_data_ok <= 1'b0;
      data_data_ok <= 1'b0;
      inst_rdata   <= 32'd0;
      data_rdata   <= 32'd0;
    end else begin
      mem_en       <= 1'b0;
      mem_wen      <= 4'b0000;
      inst_data_ok <= 1'b0;
      data_data_ok <= 1'b0;
      // Accept: latch the request straight into the memory-side registers
      if (gnt_inst || gnt_data) begin
        lat_wr    <= sel_wr;
        lat_data  <= gnt_data;
        last_data <= gnt_data;
        mem_en    <= 1'b1;
        mem_wen   <= sel_wr ? sel_wstrb : 4'b0000;
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
      end
      if (state == ISSUE) cnt <= LAT3;
      if (state == WAIT) begin
        cnt <= cnt - 3'd1;
        if (cnt == 3'd1) begin
          if (lat_data) begin
            data_data_ok <= 1'b1;
            if (!lat_wr) data_rdata <= mem_rdata;
          end else begin
            inst_data_ok <= 1'b1;
            if (!lat_wr) inst_rdata <= mem_rdata;
          end
        end
      end
    end
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-port, fixed-latency SRAM between the core's instruction-fetch requester and data-access requester. Targets a unified-memory build where the inst and data SRAM interfaces of the five-stage core cannot each have a private RAM.
- Sits between the core's inst/data request ports and the shared memory macro.
- Serialises accesses: one transaction is in flight at a time, using a request/address-accept/data-return handshake toward each requester.

Parameters:
- MEM_LAT, 1, cycles from the mem_en cycle to the mem_rdata-valid cycle. Legal range 1..7; 3-bit counter.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- resetn  input  1  asynchronous active-low reset.
- inst_req  input  1  instruction requester wants a transfer; held until inst_addr_ok.
- inst_wr  input  1  1 = write, 0 = read.
- inst_wstrb  input  4  byte enables for writes.
- inst_addr  input  32  byte address.
- inst_wdata  input  32  write data.
- inst_addr_ok  output  1  request accepted this cycle (combinational).
- inst_data_ok  output  1  one-cycle pulse: transaction complete (registered).
- inst_rdata  output  32  read data, valid while inst_data_ok=1 (registered).
- data_req, data_wr, data_wstrb, data_addr, data_wdata, data_addr_ok, data_data_ok, data_rdata: same as the inst_* group, for the data requester.
- mem_en  output  1  memory access strobe (registered).
- mem_wen  output  4  byte write enables; 0 for reads (registered).
- mem_addr  output  32  memory address (registered).
- mem_wdata  output  32  memory write data (registered).
- mem_rdata  input  32  memory read data, valid MEM_LAT cycles after the mem_en cycle.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (resetn=0, asynchronous, takes effect immediately):
  - state=IDLE, counter=0.
  - mem_en=0, mem_wen=0, mem_addr=0, mem_wdata=0.
  - both data_ok=0, both rdata=0.
  - last_grant=DATA.
- Any transaction in progress at reset is discarded; no data_ok is produced for it.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If either req=1, the arbiter picks a grant and asserts that requester's addr_ok combinationally in the same cycle.
  - It latches wr/wstrb/addr/wdata and the grant ID, then moves to ISSUE.
  - addr_ok is never asserted outside IDLE and never to both requesters at once.
- ISSUE (exactly 1 cycle): mem_en=1, mem_wen = wr ? wstrb : 4'b0000, mem_addr and mem_wdata from the latch. Loads counter=MEM_LAT, then moves to WAIT.
- WAIT (exactly MEM_LAT cycles):
  - mem_en=0, mem_wen=0; counter decrements each cycle.
  - At the edge ending the last WAIT cycle (counter==1), mem_rdata is captured into the granted requester's rdata register (reads only) → RESP.
- RESP (1 cycle):
  - Granted requester's data_ok=1; the other requester's data_ok stays 0. Then → IDLE.
  - Write transactions pulse data_ok with rdata unchanged.
  - The non-granted rdata register always holds its previous value.
- Timing: accept in cycle T → mem_en in T+1 → data_ok in T+2+MEM_LAT → next accept possible in T+3+MEM_LAT.
- Arbitration (default, fixed priority): if both req=1 in IDLE, data wins; inst is accepted at the next IDLE if it is still requesting.
- A req that drops before addr_ok has no effect.
- last_grant updates on every accept.
- mem_addr and mem_wdata hold their last values outside ISSUE.
- wstrb=4'b0000 on a write is passed through unchanged: mem_en pulses with mem_wen=0 and data_ok is still returned.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: on a tie in IDLE, grant goes to the requester opposite last_grant. After reset last_grant=DATA, so the first tie goes to inst. Non-tie cases are unchanged.
- Undefined: fixed data-over-inst priority. last_grant is still maintained but never consulted.

Test Plan:
- MEM_LAT=1, inst read:
  - Stimulus: inst_req=1, inst_wr=0, addr=0xBFC00000 in cycle 0; mem_rdata=0x3C1D0001 in cycle 2.
  - Response: inst_addr_ok=1 in cycle 0; mem_en=1, mem_wen=0, mem_addr=0xBFC00000 in cycle 1; inst_data_ok=1 and inst_rdata=0x3C1D0001 in cycle 3.
- MEM_LAT=1, data write:
  - Stimulus: data_wr=1, wstrb=4'b0011, addr=0x80000010, wdata=0x12345678 in cycle 0.
  - Response: mem_wen=4'b0011 and mem_wdata=0x12345678 in cycle 1; data_data_ok=1 in cycle 3; inst_data_ok=0 throughout; data_rdata unchanged.
- Fixed priority:
  - Stimulus: inst_req and data_req both held from cycle 0.
  - Response: data_addr_ok in cycle 0, data_data_ok in cycle 3, inst_addr_ok in cycle 4, inst_data_ok in cycle 7; busy=1 in cycles 1-3 and 5-7.
- ARB_ROUND_ROBIN_EN defined:
  - Stimulus: both requesters held for 4 transactions.
  - Response: grant order inst, data, inst, data; accepts in cycles 0, 4, 8, 12.
- MEM_LAT=4, read at cycle 0:
  - Response: mem_en in cycle 1; WAIT in cycles 2-5; data_ok in cycle 6; next addr_ok no earlier than cycle 7.
- Reset mid-transaction:
  - Stimulus: resetn=0 asynchronously in cycle 2 (WAIT), released in cycle 4; inst_req asserted in cycle 5.
  - Response: busy, mem_en and both data_ok drop to 0 immediately, and no data_ok appears for the aborted transaction; inst_addr_ok=1 in cycle 5 and the transaction completes normally in cycle 8.
